// File: rtl/gpio_pio_edge.sv
// Avalon-MM GPIO: per-bit direction, synchronised inputs, edge capture, maskable irq.
// Define GPIO_PIO_EDGE_SETCLR_EN to add atomic set (addr 4) / clear (addr 5) of data_out.
module gpio_pio_edge #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] OUT_RESET = '0,
  parameter logic [WIDTH-1:0] DIR_RESET = '0,
  parameter int unsigned      EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] direction;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] in_prev;
  logic [1:0]       arm;

  logic             wr_en;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] clear;
  logic [WIDTH-1:0] detected;
  logic [WIDTH-1:0] rd_w;
  logic             sel_data;
  logic             sel_dir;
  logic             sel_mask;
  logic             sel_edge;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdat         = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  assign sel_data = (address == 3'd0);
  assign sel_dir  = (address == 3'd1);
  assign sel_mask = (address == 3'd2);
  assign sel_edge = (address == 3'd3);

`ifdef GPIO_PIO_EDGE_SETCLR_EN
  logic sel_set;
  logic sel_clr;
  assign sel_set = (address == 3'd4);
  assign sel_clr = (address == 3'd5);
`endif

  assign clear = (wr_en && sel_edge) ? wdat : '0;

  // Capture is held off until the synchroniser has filled with real pin values.
  always_comb begin
    case (EDGE_TYPE)
      0:       detected = in_sync & ~in_prev;
      1:       detected = ~in_sync & in_prev;
      default: detected = in_sync ^ in_prev;
    endcase
    if (arm != 2'd3) detected = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= OUT_RESET;
      direction <= DIR_RESET;
      irq_mask  <= '0;
      edge_cap  <= '0;
      s1        <= '0;
      in_sync   <= '0;
      in_prev   <= '0;
      arm       <= 2'd0;
    end else begin
      s1       <= in_port;
      in_sync  <= s1;
      in_prev  <= in_sync;
      edge_cap <= detected | (edge_cap & ~clear);
      if (arm != 2'd3) arm <= arm + 2'd1;
      if (wr_en) begin
        unique case (1'b1)
          sel_data: data_out  <= wdat;
          sel_dir:  direction <= wdat;
          sel_mask: irq_mask  <= wdat;
`ifdef GPIO_PIO_EDGE_SETCLR_EN
          sel_set:  data_out  <= data_out | wdat;
          sel_clr:  data_out  <= data_out & ~wdat;
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    unique case (1'b1)
      sel_data: rd_w = in_sync;
      sel_dir:  rd_w = direction;
      sel_mask: rd_w = irq_mask;
      sel_edge: rd_w = edge_cap;
      default:  rd_w = '0;
    endcase
    readdata = '0;
    readdata[WIDTH-1:0] = rd_w;
  end

  assign out_port = data_out;
  assign oe_port  = direction;
  assign irq      = |(edge_cap & irq_mask);

endmodule
